ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/key_slot_table.sv | 81 ++++++++
 rtl/ps2_key_tracker.sv | 83 ++++++++
 tb/tb_ps2_key_tracker.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared decoder states, prefix codes and ignore-byte list
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam int NUM_IGNORE = 6;
    localparam logic [NUM_IGNORE-1:0][7:0] SC_IGNORE = {
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
    };

    localparam int NUM_SLOTS = 4;

    // Keyboard status/ack bytes that never take part in a key sequence.
    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_IGNORE; i++) begin
            if (b == SC_IGNORE[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/key_slot_table.sv
// rtl/key_slot_table.sv - four-slot pressed-key table with sticky overflow
module key_slot_table
    import ps2_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        insert,
    input  logic        remove,
    input  logic [7:0]  code,
    output logic [31:0] slots,
    output logic [2:0]  count,
    output logic        overflow
);

    logic [NUM_SLOTS-1:0][7:0] table_q;
    logic [NUM_SLOTS-1:0][7:0] table_d;
    logic [NUM_SLOTS-1:0]      hit;
    logic [NUM_SLOTS-1:0]      empty;
    logic [1:0]                free_idx;
    logic                      free_found;
    logic                      overflow_d;

    function automatic logic [2:0] count_used(input logic [NUM_SLOTS-1:0][7:0] t);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (t[i] != 8'h00) n = n + 3'd1;
        end
        return n;
    endfunction

    always_comb begin
        hit        = '0;
        empty      = '0;
        free_idx   = 2'd0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit[i]   = (table_q[i] == code);
            empty[i] = (table_q[i] == 8'h00);
        end
        // Descending scan so the lowest empty index wins.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (empty[i]) begin
                free_idx   = 2'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        table_d    = table_q;
        overflow_d = overflow;
        if (insert && (hit == '0)) begin
            if (free_found) begin
                table_d[free_idx] = code;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (remove && (hit != '0)) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (hit[i]) table_d[i] = 8'h00;
            end
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            table_q  <= '0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            table_q  <= table_d;
            count    <= count_used(table_d);
            overflow <= overflow_d;
        end
    end

    assign slots = table_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 set-2 make/break decoder feeding a four-key rollover table
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] PS2keycode,
    output logic [2:0]  key_count,
    output logic        overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_e    state;
    logic [TW-1:0] tmo_cnt;
    logic          accept;
    logic          is_prefix;
    logic          do_insert;
    logic          do_remove;

    assign accept    = byte_valid && !is_ignored(byte_in);
    assign is_prefix = (byte_in == SC_EXT) || (byte_in == SC_BRK);

    // Table strobes act on the same edge that samples the byte.
    always_comb begin
        do_insert = 1'b0;
        do_remove = 1'b0;
        if (accept && !is_prefix) begin
            if (state == IDLE || state == EXT) do_insert = 1'b1;
            else                               do_remove = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else if (byte_valid) begin
            tmo_cnt <= '0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (byte_in == SC_EXT)      state <= EXT;
                        else if (byte_in == SC_BRK) state <= BRK;
                        else                        state <= IDLE;
                    end
                    EXT: begin
                        if (byte_in == SC_BRK) state <= EXT_BRK;
                        else                   state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end else if (state != IDLE) begin
            // Abandon a stalled prefix; the >= keeps the counter from ever wrapping.
            if (tmo_cnt >= TMO_LAST) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    key_slot_table u_table (
        .clk      (Clk),
        .reset    (Reset),
        .insert   (do_insert),
        .remove   (do_remove),
        .code     (byte_in),
        .slots    (PS2keycode),
        .count    (key_count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed self-checking bench for ps2_key_tracker
module tb_ps2_key_tracker;

    localparam int TMO = 20;

    logic        clk;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic [31:0] ps2keycode;
    logic [2:0]  key_count;
    logic        overflow;

    int checks;
    int failures;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk        (clk),
        .Reset      (reset),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .PS2keycode (ps2keycode),
        .key_count  (key_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_code", ps2keycode, 32'h0);
        check("rst_count", 32'(key_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Typematic repeat leaves the table unchanged
        send(8'h1C);
        check("first_make", ps2keycode, 32'h0000_001C);
        send(8'h1D);
        send(8'h1C);
        check("repeat_code", ps2keycode, 32'h0000_1D1C);
        check("repeat_count", 32'(key_count), 32'd2);
        idle(3);
        check("hold_code", ps2keycode, 32'h0000_1D1C);

        // Extended make/break folds onto the base code
        do_reset();
        send(8'hE0); send(8'h75);
        check("ext_make", ps2keycode, 32'h0000_0075);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_break", ps2keycode, 32'h0000_0000);
        check("ext_ovf", 32'(overflow), 32'd0);

        // Full table, overflow, break without compaction
        do_reset();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h1D);
        check("full_count", 32'(key_count), 32'd4);
        send(8'h1C);
        check("full_repeat_ovf", 32'(overflow), 32'd0);
        send(8'h75);
        check("ovf_code", ps2keycode, 32'h1D23_1B1C);
        check("ovf_set", 32'(overflow), 32'd1);
        send(8'hF0); send(8'h42);
        check("miss_break_ovf", 32'(overflow), 32'd1);
        check("miss_break_code", ps2keycode, 32'h1D23_1B1C);
        send(8'hF0); send(8'h1B);
        check("brk_code", ps2keycode, 32'h1D23_001C);
        check("brk_ovf", 32'(overflow), 32'd0);
        check("brk_count", 32'(key_count), 32'd3);
        send(8'h75);
        check("refill_hole", ps2keycode, 32'h1D23_751C);

        // One idle cycle short of the timeout the prefix still applies
        do_reset();
        send(8'h1C);
        send(8'hF0);
        idle(TMO - 1);
        send(8'h1C);
        check("pre_timeout_break", ps2keycode, 32'h0);
        // Full timeout abandons the prefix
        send(8'hF0);
        idle(TMO);
        check("timeout_hold", ps2keycode, 32'h0);
        send(8'h1C);
        check("timeout_make", ps2keycode, 32'h0000_001C);
        check("timeout_count", 32'(key_count), 32'd1);

        // Reset mid-sequence discards the pending break prefix
        do_reset();
        send(8'h1C);
        send(8'hF0);
        do_reset();
        check("mid_rst_code", ps2keycode, 32'h0);
        send(8'h1C);
        check("mid_rst_make", ps2keycode, 32'h0000_001C);
        check("mid_rst_count", 32'(key_count), 32'd1);

        // Reset wins over a byte in the same cycle
        reset      = 1'b1;
        byte_in    = 8'h1D;
        byte_valid = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        byte_valid = 1'b0;
        check("rst_priority", ps2keycode, 32'h0);

        // Status bytes interleaved inside a sequence are ignored
        send(8'h1C); send(8'hAA); send(8'hF0); send(8'hFA); send(8'h1C);
        check("ign_code", ps2keycode, 32'h0);
        check("ign_count", 32'(key_count), 32'd0);
        send(8'h1C);
        check("ign_back_idle", ps2keycode, 32'h0000_001C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
